// File: rtl/uart_hex_rx.sv
// Receive-side command parser: turns CR/LF-terminated lines of ASCII hex digits
// into seq_dp_width-bit words presented over a valid/ready handshake.
module uart_hex_rx #(
    parameter int unsigned seq_dp_width = 16,
    parameter int unsigned uart_num_nib = seq_dp_width / 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    output logic [seq_dp_width-1:0] o_cmd_data,
    output logic                    o_cmd_valid,
    input  logic                    i_cmd_ready,
    output logic                    o_err,
    output logic [1:0]              o_err_code
);

    localparam int unsigned     CntW       = $clog2(uart_num_nib + 1);
    localparam logic [CntW-1:0] CntMax     = CntW'(uart_num_nib);
    localparam logic [1:0]      ErrBadChar = 2'd1;
    localparam logic [1:0]      ErrTooLong = 2'd2;
    localparam logic [1:0]      ErrOverrun = 2'd3;

    typedef enum logic [1:0] {StIdle, StAcc, StBad} state_e;

    state_e                  state_q, state_d;
    logic [seq_dp_width-1:0] acc_q, acc_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [1:0]              bad_code_q, bad_code_d;
    logic [seq_dp_width-1:0] cmd_data_q, cmd_data_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    err_q, err_d;
    logic [1:0]              err_code_q, err_code_d;

    logic       is_hex;
    logic       is_term;
    logic [3:0] nibble;
    logic       word_done;

    always_comb begin
        is_hex = 1'b1;
        nibble = i_rx_data[3:0];
        if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
            nibble = i_rx_data[3:0];
        end else if ((i_rx_data >= 8'h41 && i_rx_data <= 8'h46) ||
                     (i_rx_data >= 8'h61 && i_rx_data <= 8'h66)) begin
            nibble = i_rx_data[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
        is_term = (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            bad_code_q  <= 2'd0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bad_code_q  <= bad_code_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bad_code_d  = bad_code_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = cmd_valid_q & ~i_cmd_ready;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        word_done   = 1'b0;

        if (i_rx_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (is_hex) begin
                        acc_d   = seq_dp_width'(nibble);
                        cnt_d   = CntW'(1);
                        state_d = StAcc;
                    end else if (!is_term) begin
                        bad_code_d = ErrBadChar;
                        state_d    = StBad;
                    end
                end
                StAcc: begin
                    if (is_term) begin
                        word_done = 1'b1;
                        acc_d     = '0;
                        cnt_d     = '0;
                        state_d   = StIdle;
                    end else if (is_hex && cnt_q < CntMax) begin
                        acc_d = (acc_q << 4) | seq_dp_width'(nibble);
                        cnt_d = cnt_q + CntW'(1);
                    end else begin
                        bad_code_d = is_hex ? ErrTooLong : ErrBadChar;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = StBad;
                    end
                end
                StBad: begin
                    if (is_term) begin
                        err_d      = 1'b1;
                        err_code_d = bad_code_q;
                        state_d    = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // A word completing while the slot is busy is dropped; the pending word stays.
        if (word_done) begin
            if (!cmd_valid_q || i_cmd_ready) begin
                cmd_data_d  = acc_q;
                cmd_valid_d = 1'b1;
            end else begin
                err_d      = 1'b1;
                err_code_d = ErrOverrun;
            end
        end
    end

    always_comb begin
        o_cmd_data  = cmd_data_q;
        o_cmd_valid = cmd_valid_q;
        o_err       = err_q;
        o_err_code  = err_code_q;
    end

endmodule

// File: tb/tb_uart_hex_rx.sv
// Bench for uart_hex_rx: table of lines, hand-written handshake/reset sequences,
// and random lines checked against a line-level parsing model.
module tb_uart_hex_rx;

    localparam int W   = 16;
    localparam int NIB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic [W-1:0] cmd_data;
    logic         cmd_valid;
    logic         cmd_ready = 1'b1;
    logic         err;
    logic [1:0]   err_code;

    uart_hex_rx #(.seq_dp_width(W), .uart_num_nib(NIB)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_cmd_data (cmd_data),
        .o_cmd_valid(cmd_valid),
        .i_cmd_ready(cmd_ready),
        .o_err      (err),
        .o_err_code (err_code)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    int           words_seen = 0;
    int           errs_seen = 0;
    logic [W-1:0] last_word = '0;
    logic [1:0]   last_code = 2'd0;

    // Accepted words and error-pulse cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            words_seen <= words_seen + 1;
            last_word  <= cmd_data;
        end
        if (err) begin
            errs_seen <= errs_seen + 1;
            last_code <= err_code;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    typedef struct {
        string        name;
        string        line;
        bit           ew;
        logic [W-1:0] word;
        bit           ee;
        logic [1:0]   code;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit is_hex_c(input byte unsigned c);
        return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
    endfunction

    function automatic bit is_term_c(input byte unsigned c);
        return c == 8'h0D || c == 8'h0A;
    endfunction

    function automatic int hex_val(input byte unsigned c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return int'(c) - 55;
    endfunction

    // Parses the first line of b: the earliest problem (bad char or digit overflow) wins.
    task automatic model(input byte unsigned b[$], output bit ew, output logic [W-1:0] word,
                         output bit ee, output logic [1:0] code);
        int ndig = 0;
        int val = 0;
        int c_err = 0;
        foreach (b[i]) begin
            if (is_term_c(b[i])) break;
            if (c_err == 0) begin
                if (!is_hex_c(b[i])) c_err = 1;
                else if (ndig == NIB) c_err = 2;
                else begin
                    val = val * 16 + hex_val(b[i]);
                    ndig++;
                end
            end
        end
        ee   = (c_err != 0);
        code = 2'(c_err);
        ew   = !ee && ndig > 0;
        word = W'(val);
    endtask

    task automatic to_q(input string s, output byte unsigned q[$]);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    task automatic send_bytes(input byte unsigned b[$], input bit gaps);
        foreach (b[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    rx_valid = 1'b0;
                    rx_data  = 8'($urandom);
                    tick(1);
                end
            end
            rx_valid = 1'b1;
            rx_data  = b[i];
            tick(1);
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic run_line(input string name, input byte unsigned b[$], input bit ew,
                            input logic [W-1:0] eword, input bit ee, input logic [1:0] ecode,
                            input bit gaps);
        int w0;
        int e0;
        w0 = words_seen;
        e0 = errs_seen;
        send_bytes(b, gaps);
        tick(2);
        check({name, " words"}, 32'(words_seen - w0), {31'd0, ew});
        if (ew) check({name, " word"}, 32'(last_word), 32'(eword));
        check({name, " errs"}, 32'(errs_seen - e0), {31'd0, ee});
        if (ee) check({name, " code"}, 32'(last_code), 32'(ecode));
    endtask

    initial begin
        byte unsigned q[$];
        bit           ew;
        bit           ee;
        logic [W-1:0] ew_word;
        logic [1:0]   ecode;
        int           w0;
        int           e0;

        vecs.push_back('{"hex mixed", "1A2f\x0D\x0A", 1'b1, 16'h1A2F, 1'b0, 2'd0});
        vecs.push_back('{"single", "7\x0A", 1'b1, 16'h0007, 1'b0, 2'd0});
        vecs.push_back('{"blank", "\x0D\x0A\x0D", 1'b0, 16'h0000, 1'b0, 2'd0});
        vecs.push_back('{"lead zero", "0005\x0D", 1'b1, 16'h0005, 1'b0, 2'd0});
        vecs.push_back('{"too long", "123456\x0D", 1'b0, 16'h0000, 1'b1, 2'd2});
        vecs.push_back('{"lower", "abcd\x0D", 1'b1, 16'hABCD, 1'b0, 2'd0});
        vecs.push_back('{"max", "ffff\x0A", 1'b1, 16'hFFFF, 1'b0, 2'd0});
        vecs.push_back('{"space", " 1\x0D", 1'b0, 16'h0000, 1'b1, 2'd1});
        vecs.push_back('{"bad last", "fffg\x0D", 1'b0, 16'h0000, 1'b1, 2'd1});
        vecs.push_back('{"long first", "12345G\x0D", 1'b0, 16'h0000, 1'b1, 2'd2});
        vecs.push_back('{"upper F", "F\x0D", 1'b1, 16'h000F, 1'b0, 2'd0});

        @(posedge clk);
        #1;
        check("reset data", 32'(cmd_data), 32'd0);
        check("reset valid", 32'(cmd_valid), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset code", 32'(err_code), 32'd0);
        rst = 1'b1;
        tick(2);

        foreach (vecs[i]) begin
            to_q(vecs[i].line, q);
            run_line(vecs[i].name, q, vecs[i].ew, vecs[i].word, vecs[i].ee, vecs[i].code, 1'b0);
        end

        // Error latency: pulse in the cycle after the CR, exactly one cycle long.
        to_q("12G4\x0D", q);
        send_bytes(q, 1'b0);
        check("bad err", 32'(err), 32'd1);
        check("bad code", 32'(err_code), 32'd1);
        tick(1);
        check("bad err drop", 32'(err), 32'd0);
        to_q("0005\x0D", q);
        send_bytes(q, 1'b0);
        check("after bad valid", 32'(cmd_valid), 32'd1);
        check("after bad data", 32'(cmd_data), 32'h0005);
        tick(2);

        // Overrun with the slot held.
        cmd_ready = 1'b0;
        to_q("AAAA\x0D", q);
        send_bytes(q, 1'b0);
        check("ovr valid", 32'(cmd_valid), 32'd1);
        check("ovr data", 32'(cmd_data), 32'hAAAA);
        to_q("BBBB\x0D", q);
        send_bytes(q, 1'b0);
        check("ovr err", 32'(err), 32'd1);
        check("ovr code", 32'(err_code), 32'd3);
        check("ovr hold", 32'(cmd_data), 32'hAAAA);
        tick(1);
        check("ovr err drop", 32'(err), 32'd0);
        check("ovr code hold", 32'(err_code), 32'd3);
        w0 = words_seen;
        cmd_ready = 1'b1;
        tick(1);
        check("ovr valid drop", 32'(cmd_valid), 32'd0);
        tick(2);
        check("ovr accepted", 32'(words_seen - w0), 32'd1);
        check("ovr acc word", 32'(last_word), 32'hAAAA);

        // Completion in the same cycle the old word is accepted.
        cmd_ready = 1'b0;
        to_q("AAAA\x0D", q);
        send_bytes(q, 1'b0);
        to_q("BBBB", q);
        send_bytes(q, 1'b0);
        w0 = words_seen;
        e0 = errs_seen;
        rx_valid  = 1'b1;
        rx_data   = 8'h0D;
        cmd_ready = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        check("simul valid", 32'(cmd_valid), 32'd1);
        check("simul data", 32'(cmd_data), 32'hBBBB);
        check("simul err", 32'(err), 32'd0);
        tick(3);
        check("simul words", 32'(words_seen - w0), 32'd2);
        check("simul last", 32'(last_word), 32'hBBBB);
        check("simul errs", 32'(errs_seen - e0), 32'd0);

        // Asynchronous reset with a word pending and a line half-received.
        cmd_ready = 1'b0;
        to_q("5\x0D", q);
        send_bytes(q, 1'b0);
        to_q("12", q);
        send_bytes(q, 1'b0);
        rst = 1'b0;
        #1;
        check("arst valid", 32'(cmd_valid), 32'd0);
        check("arst data", 32'(cmd_data), 32'd0);
        check("arst code", 32'(err_code), 32'd0);
        tick(1);
        rst = 1'b1;
        cmd_ready = 1'b1;
        tick(1);
        to_q("3\x0D", q);
        run_line("post reset", q, 1'b1, 16'h0003, 1'b0, 2'd0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            byte unsigned c;
            q = {};
            repeat ($urandom_range(0, 6)) begin
                if ($urandom_range(0, 9) < 8) begin
                    int d;
                    d = $urandom_range(0, 15);
                    if (d < 10) c = 8'(48 + d);
                    else c = 8'(($urandom_range(0, 1) != 0 ? 65 : 97) + d - 10);
                end else begin
                    do c = 8'($urandom); while (is_hex_c(c) || is_term_c(c));
                end
                q.push_back(c);
            end
            q.push_back($urandom_range(0, 1) != 0 ? 8'h0D : 8'h0A);
            if ($urandom_range(0, 1) != 0) q.push_back(8'h0A);
            model(q, ew, ew_word, ee, ecode);
            run_line("rand", q, ew, ew_word, ee, ecode, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_hex_rx.md
# uart_hex_rx

Receive-side command parser sitting directly downstream of the UART receiver in the UART top-level. It consumes the received byte stream (`o_rx_data`/`o_rx_valid`), accumulates ASCII hex digits into a `seq_dp_width`-bit word, and presents each CR/LF-terminated line as one word to the sequencer over a valid/ready handshake. It is the receive-path counterpart of the existing hex-nibble transmit path, which prints words as `uart_num_nib` hex digits followed by NL and CR.

## Interface
- `seq_dp_width`, 16: output word width; must be a multiple of 4.
- `uart_num_nib`, `seq_dp_width/4`: maximum hex digits per line.
- `clk`  in  1  single clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-low reset; it asserts immediately and is released synchronously by the integrator.
- `i_rx_data`  in  8  received byte from the UART.
- `i_rx_valid`  in  1  one-cycle strobe; `i_rx_data` is valid in that cycle.
- `o_cmd_data`  out  `seq_dp_width`  parsed word, right-aligned and zero-extended.
- `o_cmd_valid`  out  1  word available; held high until accepted.
- `i_cmd_ready`  in  1  downstream accepts the word when both valid and ready are high.
- `o_err`  out  1  one-cycle error pulse.
- `o_err_code`  out  2  qualified by `o_err`: 1 = bad character, 2 = too many digits, 3 = overrun.

## Operation
- Byte classes:
  - Hex digit: `0`–`9`, `A`–`F`, `a`–`f`.
  - Terminator: 0x0D or 0x0A.
  - Anything else is invalid, including space.
- State machine has three states: stIdle (no digits), stAcc (≥1 digit), stBad (discarding).
- stIdle:
  - Hex digit: accumulator ← nibble, count ← 1, go to stAcc.
  - Terminator: ignored, stay in stIdle. This absorbs CR/LF pairs and blank lines.
  - Invalid byte: go to stBad, with error code 1 latched.
- stAcc:
  - Hex digit with count < `uart_num_nib`: accumulator ← {accumulator[W-5:0], nibble}, count ← count+1.
  - Hex digit with count = `uart_num_nib`: go to stBad, code 2.
  - Invalid byte: go to stBad, code 1.
  - Terminator: complete the word, clear accumulator and count, go to stIdle.
- stBad:
  - Every non-terminator byte is discarded.
  - On a terminator: pulse `o_err` with the latched code, no word is produced, go to stIdle.
- Word completion:
  - If the output slot is free (`o_cmd_valid`=0, or `i_cmd_ready`=1 in the same cycle), load `o_cmd_data` and set `o_cmd_valid`.
  - Otherwise drop the new word and pulse `o_err` with code 3. The pending word is kept unchanged.
- Handshake:
  - `o_cmd_data` is stable while `o_cmd_valid`=1.
  - `o_cmd_valid` clears on the cycle after valid&ready, unless a new word loads in that same cycle, in which case it stays high with the new data.
- `i_rx_valid`=0 means no state change, apart from output handshake clearing.

## Timing
- Reset values: `o_cmd_data`=0, `o_cmd_valid`=0, `o_err`=0, `o_err_code`=0; accumulator=0, count=0, state=stIdle.
- Reset applied mid-line or with a word pending discards everything; no error is reported.
- Latency:
  - Terminator strobed in cycle N gives `o_cmd_valid` or `o_err` high in cycle N+1.
  - `o_err` is high for exactly one cycle.
  - `o_err_code` holds its value until the next error.
- Throughput: one byte per cycle is accepted; back-to-back `i_rx_valid` is legal.
- Simultaneous events (completion in the same cycle as valid&ready of the old word): the old word is counted as consumed and the new word loads. No overrun is reported.
- Count width is clog2(`uart_num_nib`+1) bits. Count never wraps; overflow is caught by the stBad transition.

## Test plan
- Line "1A2f\r\n" (`seq_dp_width`=16), `i_cmd_ready`=1 → one word 0x1A2F, valid for one cycle; the trailing LF produces nothing.
- Line "7\n" → word 0x0007. Line "\r\n\r" alone → no valid, no error.
- Line "12G4\r" → no word; `o_err` pulses with code 1 one cycle after the CR. The next line "0005\r" → 0x0005.
- Line "123456\r" → no word; `o_err` with code 2. The fifth digit triggers stBad.
- `i_cmd_ready`=0, lines "AAAA\r" then "BBBB\r" → `o_cmd_valid` holds 0xAAAA; `o_err` code 3 on the second CR. Raising ready → 0xAAAA accepted, valid drops, 0xBBBB is never produced.
- Ready raised in the same cycle the second line's CR completes → 0xAAAA consumed, 0xBBBB valid next cycle, no error.
- Assert `rst` low after "12" → outputs return to zero asynchronously. After release, "3\r" → 0x0003.
